// File: rtl/heap_sort_seq.sv
// heap_sort_seq: clocked heap sort engine.
// A job latches the packed key array, builds a heap, then repeatedly moves the
// heap root to the end of the shrinking heap. Each clock performs at most one
// compare/swap step. Every key carries a tag holding its original position, so
// the result reports both the sorted keys and the permutation that produced them.
// The sort order (ascending/descending) is chosen per job.
module heap_sort_seq #(
  parameter int  ARRAY_SIZE   = 32,
  parameter int  ELEMENT_SIZE = 32,
  parameter int  DEBUG        = 0,
  localparam int INDEX_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 order_i,
  input  logic [ARRAY_SIZE*ELEMENT_SIZE-1:0]   array_i,
  output logic                                 busy,
  output logic                                 done,
  output logic [ARRAY_SIZE*ELEMENT_SIZE-1:0]   array_o,
  output logic [ARRAY_SIZE*INDEX_W-1:0]        index_o
);

  // Heap length must be able to hold the value ARRAY_SIZE itself.
  localparam int LEN_W = $clog2(ARRAY_SIZE + 1);
  // Child indices 2*cur+1 / 2*cur+2 can exceed the index range; keep two spare bits.
  localparam int CH_W  = INDEX_W + 2;

  localparam logic [INDEX_W-1:0] NODE_INIT =
    (ARRAY_SIZE > 1) ? INDEX_W'(ARRAY_SIZE / 2 - 1) : {INDEX_W{1'b0}};
  localparam logic [LEN_W-1:0]   LEN_INIT  = LEN_W'(ARRAY_SIZE);
  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SIFT    = 2'd1,
    ST_EXTRACT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    PH_BUILD   = 1'b0,
    PH_EXTRACT = 1'b1
  } phase_t;

  // "a beats b": the key that should sit closer to the heap root.
  // Strict comparison, so equal keys never trigger a swap.
  function automatic logic beats(input logic [ELEMENT_SIZE-1:0] a,
                                 input logic [ELEMENT_SIZE-1:0] b,
                                 input logic                    ord);
    logic res;
    if (ord) begin
      res = (a < b);
    end else begin
      res = (a > b);
    end
    return res;
  endfunction

  // Job storage
  logic [ELEMENT_SIZE-1:0] val_r [ARRAY_SIZE];
  logic [INDEX_W-1:0]      idx_r [ARRAY_SIZE];
  logic                    ord_r;
  logic [LEN_W-1:0]        len_r;
  logic [INDEX_W-1:0]      node_r;
  logic [INDEX_W-1:0]      cur_r;
  phase_t                  phase_r;
  state_t                  state_r;
  state_t                  state_next_s;

  // Output registers
  logic                               busy_r;
  logic                               done_r;
  logic [ARRAY_SIZE*ELEMENT_SIZE-1:0] array_o_r;
  logic [ARRAY_SIZE*INDEX_W-1:0]      index_o_r;

  // Sift comparison network
  logic [CH_W-1:0]         left_w_s;
  logic [CH_W-1:0]         right_w_s;
  logic [CH_W-1:0]         len_w_s;
  logic [INDEX_W-1:0]      left_idx_s;
  logic [INDEX_W-1:0]      right_idx_s;
  logic                    left_ok_s;
  logic                    right_ok_s;
  logic [INDEX_W-1:0]      best_idx_s;
  logic [ELEMENT_SIZE-1:0] best_val_s;
  logic [LEN_W-1:0]        len_m1_s;
  logic [INDEX_W-1:0]      last_idx_s;

  // Control strobes from the FSM to the datapath
  logic load_s;
  logic sift_swap_s;
  logic node_step_s;
  logic to_extract_s;
  logic ext_swap_s;

  // Pick the winner among cur and its in-heap children (left first, then right).
  always_comb begin
    left_w_s    = {1'b0, cur_r, 1'b1};
    right_w_s   = left_w_s + {{(CH_W-1){1'b0}}, 1'b1};
    len_w_s     = {{(CH_W-LEN_W){1'b0}}, len_r};
    left_idx_s  = left_w_s[INDEX_W-1:0];
    right_idx_s = right_w_s[INDEX_W-1:0];
    left_ok_s   = (left_w_s < len_w_s);
    right_ok_s  = (right_w_s < len_w_s);
    best_idx_s  = cur_r;
    best_val_s  = val_r[cur_r];
    if (left_ok_s && beats(val_r[left_idx_s], best_val_s, ord_r)) begin
      best_idx_s = left_idx_s;
      best_val_s = val_r[left_idx_s];
    end else begin
      best_idx_s = best_idx_s;
    end
    if (right_ok_s && beats(val_r[right_idx_s], best_val_s, ord_r)) begin
      best_idx_s = right_idx_s;
      best_val_s = val_r[right_idx_s];
    end else begin
      best_idx_s = best_idx_s;
    end
    len_m1_s   = len_r - LEN_ONE;
    last_idx_s = len_m1_s[INDEX_W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state and datapath strobes.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    sift_swap_s  = 1'b0;
    node_step_s  = 1'b0;
    to_extract_s = 1'b0;
    ext_swap_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // busy_r is still high during the done cycle, which blocks a start there.
        if (start && !busy_r) begin
          load_s = 1'b1;
          if (ARRAY_SIZE == 1) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_SIFT;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SIFT: begin
        if (best_idx_s != cur_r) begin
          sift_swap_s  = 1'b1;
          state_next_s = ST_SIFT;
        end else if (phase_r == PH_BUILD) begin
          if (node_r != {INDEX_W{1'b0}}) begin
            node_step_s  = 1'b1;
            state_next_s = ST_SIFT;
          end else begin
            to_extract_s = 1'b1;
            state_next_s = ST_EXTRACT;
          end
        end else begin
          state_next_s = ST_EXTRACT;
        end
      end
      ST_EXTRACT: begin
        if (len_r == LEN_ONE) begin
          state_next_s = ST_DONE;
        end else begin
          ext_swap_s   = 1'b1;
          state_next_s = ST_SIFT;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Key/tag storage and heap bookkeeping, driven by the FSM strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ARRAY_SIZE; k++) begin
        val_r[k] <= {ELEMENT_SIZE{1'b0}};
        idx_r[k] <= {INDEX_W{1'b0}};
      end
      ord_r   <= 1'b0;
      len_r   <= {LEN_W{1'b0}};
      node_r  <= {INDEX_W{1'b0}};
      cur_r   <= {INDEX_W{1'b0}};
      phase_r <= PH_BUILD;
    end else if (load_s) begin
      for (int k = 0; k < ARRAY_SIZE; k++) begin
        val_r[k] <= array_i[k*ELEMENT_SIZE +: ELEMENT_SIZE];
        idx_r[k] <= INDEX_W'(k);
      end
      ord_r   <= order_i;
      len_r   <= LEN_INIT;
      node_r  <= NODE_INIT;
      cur_r   <= NODE_INIT;
      phase_r <= PH_BUILD;
    end else if (sift_swap_s) begin
      val_r[cur_r]      <= val_r[best_idx_s];
      val_r[best_idx_s] <= val_r[cur_r];
      idx_r[cur_r]      <= idx_r[best_idx_s];
      idx_r[best_idx_s] <= idx_r[cur_r];
      cur_r             <= best_idx_s;
    end else if (node_step_s) begin
      node_r <= node_r - {{(INDEX_W-1){1'b0}}, 1'b1};
      cur_r  <= node_r - {{(INDEX_W-1){1'b0}}, 1'b1};
    end else if (to_extract_s) begin
      phase_r <= PH_EXTRACT;
    end else if (ext_swap_s) begin
      // Root (current winner) goes to the end of the heap, which then shrinks.
      val_r[0]          <= val_r[last_idx_s];
      val_r[last_idx_s] <= val_r[0];
      idx_r[0]          <= idx_r[last_idx_s];
      idx_r[last_idx_s] <= idx_r[0];
      len_r             <= len_m1_s;
      cur_r             <= {INDEX_W{1'b0}};
    end else begin
      cur_r <= cur_r;
    end
  end

  // Registered status and result; results hold until the next job completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      array_o_r <= {(ARRAY_SIZE*ELEMENT_SIZE){1'b0}};
      index_o_r <= {(ARRAY_SIZE*INDEX_W){1'b0}};
    end else begin
      // Busy stays high through the cycle in which done is pulsed.
      busy_r <= (state_next_s != ST_IDLE) || (state_r == ST_DONE);
      done_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        for (int k = 0; k < ARRAY_SIZE; k++) begin
          array_o_r[k*ELEMENT_SIZE +: ELEMENT_SIZE] <= val_r[k];
          index_o_r[k*INDEX_W +: INDEX_W]           <= idx_r[k];
        end
      end else begin
        array_o_r <= array_o_r;
        index_o_r <= index_o_r;
      end
    end
  end

  generate
    if (DEBUG != 0) begin : g_debug
      // Per-step tracing is attached from the simulation side; no hardware here.
    end
  endgenerate

  assign busy    = busy_r;
  assign done    = done_r;
  assign array_o = array_o_r;
  assign index_o = index_o_r;

endmodule

// File: tb/tb_heap_sort_seq.sv
// tb_heap_sort_seq: known-answer vectors, multi-cycle corner cases and random
// jobs for heap_sort_seq at N=8/W=8, N=1/W=8 and N=32/W=32.
module tb_heap_sort_seq;

  logic clk = 1'b0;
  logic rst;

  logic         start8, order8, busy8, done8;
  logic [63:0]  arr_in8, arr_out8;
  logic [23:0]  idx_out8;

  logic         start1, order1, busy1, done1;
  logic [7:0]   arr_in1, arr_out1;
  logic [0:0]   idx_out1;

  logic           start32, order32, busy32, done32;
  logic [1023:0]  arr_in32, arr_out32;
  logic [159:0]   idx_out32;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_keys   [32];
  logic [31:0] m_sorted [32];

  typedef struct {
    logic [63:0] keys;
    logic        ord;
    logic [63:0] exp_arr;
    logic [23:0] exp_idx;
  } vec8_t;

  vec8_t vt [4];

  heap_sort_seq #(.ARRAY_SIZE(8), .ELEMENT_SIZE(8), .DEBUG(0)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .order_i(order8), .array_i(arr_in8),
    .busy(busy8), .done(done8), .array_o(arr_out8), .index_o(idx_out8));

  heap_sort_seq #(.ARRAY_SIZE(1), .ELEMENT_SIZE(8), .DEBUG(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .order_i(order1), .array_i(arr_in1),
    .busy(busy1), .done(done1), .array_o(arr_out1), .index_o(idx_out1));

  heap_sort_seq #(.ARRAY_SIZE(32), .ELEMENT_SIZE(32), .DEBUG(0)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .order_i(order32), .array_i(arr_in32),
    .busy(busy32), .done(done32), .array_o(arr_out32), .index_o(idx_out32));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int limit);
    checks++;
    if (act > limit) begin
      errors++;
      $display("FAIL %s: got %0d expected <= %0d", name, act, limit);
    end
  endtask

  function automatic logic [63:0] pk8(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [23:0] pi8(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    return {a7[2:0], a6[2:0], a5[2:0], a4[2:0], a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
  endfunction

  // Reference: plain insertion sort of m_keys[0..n-1] into m_sorted.
  task automatic model_sort(input int n, input logic ord);
    logic [31:0] t;
    int j;
    for (int i = 0; i < n; i++) m_sorted[i] = m_keys[i];
    for (int i = 1; i < n; i++) begin
      t = m_sorted[i];
      j = i - 1;
      while (j >= 0 && (ord ? (m_sorted[j] < t) : (m_sorted[j] > t))) begin
        m_sorted[j+1] = m_sorted[j];
        j--;
      end
      m_sorted[j+1] = t;
    end
  endtask

  // Compare a DUT result against the reference: sorted keys, permutation, key mapping.
  task automatic check_vs_model(input string tag, input int n, input int ew, input int iw,
                                input logic [1023:0] arr, input logic [159:0] idx,
                                input logic ord);
    logic [31:0] got [32];
    int          ix  [32];
    bit          seen [32];
    int          first_bad;
    bit          perm_ok;
    bit          map_ok;
    model_sort(n, ord);
    first_bad = -1;
    perm_ok   = 1'b1;
    map_ok    = 1'b1;
    for (int k = 0; k < 32; k++) seen[k] = 1'b0;
    for (int k = 0; k < n; k++) begin
      got[k] = 32'(arr >> (k*ew));
      if (ew < 32) got[k] = got[k] & ((32'd1 << ew) - 32'd1);
      ix[k] = int'(32'(idx >> (k*iw)) & ((32'd1 << iw) - 32'd1));
      if (got[k] !== m_sorted[k] && first_bad < 0) first_bad = k;
      if (ix[k] >= n || seen[ix[k]]) begin
        perm_ok = 1'b0;
      end else begin
        seen[ix[k]] = 1'b1;
        if (m_keys[ix[k]] !== got[k]) map_ok = 1'b0;
      end
    end
    if (first_bad < 0) first_bad = 0;
    chk($sformatf("%s_keys[%0d]", tag, first_bad), 64'(got[first_bad]), 64'(m_sorted[first_bad]));
    chk({tag, "_perm"}, 64'(perm_ok), 64'd1);
    chk({tag, "_map"}, 64'(map_ok), 64'd1);
  endtask

  // --- N=8 helpers (call at a negedge) ---
  task automatic go8(input logic [63:0] keys, input logic ord);
    start8 = 1'b1; arr_in8 = keys; order8 = ord;
    @(negedge clk);
    start8 = 1'b0; arr_in8 = {$urandom, $urandom}; order8 = ~ord;
  endtask

  task automatic wait8(input int lat0, output int lat);
    lat = lat0;
    while (done8 !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("done8_seen", 64'(done8), 64'd1);
    chk("busy8_at_done", 64'(busy8), 64'd1);
    chk_le("lat8_bound", lat, 44);
  endtask

  task automatic end8();
    @(negedge clk);
    chk("done8_pulse_width", 64'(done8), 64'd0);
    chk("busy8_after_done", 64'(busy8), 64'd0);
  endtask

  task automatic set_model8(input logic [63:0] keys);
    for (int k = 0; k < 8; k++) m_keys[k] = 32'(keys >> (k*8)) & 32'hFF;
  endtask

  // --- N=32 helpers ---
  task automatic go32(input logic ord);
    start32 = 1'b1; order32 = ord;
    @(negedge clk);
    start32 = 1'b0; order32 = ~ord;
    for (int k = 0; k < 32; k++) arr_in32[k*32 +: 32] = $urandom;
  endtask

  task automatic wait32(output int lat);
    lat = 1;
    while (done32 !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("done32_seen", 64'(done32), 64'd1);
    chk_le("lat32_bound", lat, 228);
  endtask

  initial begin
    int lat;
    logic [63:0] keys_a, keys_b;

    vt[0].keys = pk8(5,3,7,1,6,2,8,4);  vt[0].ord = 1'b0;
    vt[0].exp_arr = pk8(1,2,3,4,5,6,7,8); vt[0].exp_idx = pi8(3,5,1,7,0,4,2,6);
    vt[1].keys = pk8(5,3,7,1,6,2,8,4);  vt[1].ord = 1'b1;
    vt[1].exp_arr = pk8(8,7,6,5,4,3,2,1); vt[1].exp_idx = pi8(6,2,4,0,7,1,5,3);
    vt[2].keys = pk8('h00,'hFF,'h80,'h01,'h7F,'hFE,'h02,'h81); vt[2].ord = 1'b0;
    vt[2].exp_arr = pk8('h00,'h01,'h02,'h7F,'h80,'h81,'hFE,'hFF); vt[2].exp_idx = pi8(0,3,6,4,2,7,5,1);
    vt[3].keys = pk8('h00,'hFF,'h80,'h01,'h7F,'hFE,'h02,'h81); vt[3].ord = 1'b1;
    vt[3].exp_arr = pk8('hFF,'hFE,'h81,'h80,'h7F,'h02,'h01,'h00); vt[3].exp_idx = pi8(1,5,7,2,4,6,3,0);

    rst = 1'b1;
    start8 = 1'b0; order8 = 1'b0; arr_in8 = 64'd0;
    start1 = 1'b0; order1 = 1'b0; arr_in1 = 8'd0;
    start32 = 1'b0; order32 = 1'b0; arr_in32 = 1024'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_arr8", arr_out8, 64'd0);
    chk("rst_idx8", 64'(idx_out8), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_arr32", 64'(arr_out32[63:0]), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);

    // Known-answer table, jobs issued back to back (start in the cycle after done)
    for (int i = 0; i < 4; i++) begin
      go8(vt[i].keys, vt[i].ord);
      wait8(1, lat);
      chk($sformatf("vec%0d_arr", i), arr_out8, vt[i].exp_arr);
      chk($sformatf("vec%0d_idx", i), 64'(idx_out8), 64'(vt[i].exp_idx));
      end8();
    end

    // All keys equal
    keys_a = {8{8'hAA}};
    go8(keys_a, 1'b0);
    wait8(1, lat);
    set_model8(keys_a);
    check_vs_model("allAA", 8, 8, 3, 1024'(arr_out8), 160'(idx_out8), 1'b0);
    end8();

    // Start while busy is ignored; then a start in the cycle after done is taken
    keys_a = pk8(9,200,17,3,3,150,64,1);
    keys_b = pk8(250,1,2,3,4,5,6,7);
    go8(keys_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; arr_in8 = keys_b; order8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(4, lat);
    set_model8(keys_a);
    check_vs_model("ignored_start", 8, 8, 3, 1024'(arr_out8), 160'(idx_out8), 1'b0);
    end8();
    go8(keys_b, 1'b1);
    wait8(1, lat);
    set_model8(keys_b);
    check_vs_model("b2b_second", 8, 8, 3, 1024'(arr_out8), 160'(idx_out8), 1'b1);
    end8();

    // Reset in the middle of a sort clears outputs asynchronously
    go8(pk8(11,22,33,44,55,66,77,88), 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy8", 64'(busy8), 64'd0);
    chk("midrst_done8", 64'(done8), 64'd0);
    chk("midrst_arr8", arr_out8, 64'd0);
    chk("midrst_idx8", 64'(idx_out8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    keys_a = pk8(40,10,30,20,80,60,70,50);
    go8(keys_a, 1'b0);
    wait8(1, lat);
    chk("after_rst_arr", arr_out8, pk8(10,20,30,40,50,60,70,80));
    chk("after_rst_idx", 64'(idx_out8), 64'(pi8(1,3,2,0,7,5,6,4)));
    end8();

    // N=1: two back-to-back jobs, each done two cycles after start
    for (int j = 0; j < 2; j++) begin
      start1 = 1'b1; arr_in1 = (j == 0) ? 8'h5A : 8'hC3; order1 = j[0];
      @(negedge clk);
      start1 = 1'b0; arr_in1 = 8'h00;
      lat = 1;
      while (done1 !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("n1_lat%0d", j), 64'(lat), 64'd2);
      chk($sformatf("n1_busy%0d", j), 64'(busy1), 64'd1);
      chk($sformatf("n1_arr%0d", j), 64'(arr_out1), (j == 0) ? 64'h5A : 64'hC3);
      chk($sformatf("n1_idx%0d", j), 64'(idx_out1), 64'd0);
      @(negedge clk);
      chk($sformatf("n1_pulse%0d", j), 64'(done1), 64'd0);
    end

    // Random jobs at N=32, W=32; odd jobs use a narrow key range to force duplicates
    for (int j = 0; j < 200; j++) begin
      logic ord;
      ord = 1'($urandom_range(0, 1));
      for (int k = 0; k < 32; k++) begin
        m_keys[k] = (j % 2 == 1) ? ($urandom & 32'h7) : $urandom;
        arr_in32[k*32 +: 32] = m_keys[k];
      end
      go32(ord);
      wait32(lat);
      check_vs_model($sformatf("rnd%0d", j), 32, 32, 5, arr_out32, idx_out32, ord);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
